// File: rtl/btb_assoc_pkg.sv
// Shared types, counter constants and address helpers for the set-associative BTB.
package btb_types;

  // Widest tag occurs at INDEX_BITS=0; narrower tags are stored zero-extended.
  localparam int TAG_W = 30;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int index_bits);
    return TAG_W'(pc >> (index_bits + 2));
  endfunction

endpackage

// File: rtl/btb_assoc_way.sv
// One BTB way: entry array with two combinational read ports, a registered
// write port and a global invalidate. Tags and targets are intentionally unreset.
module btb_way
  import btb_types::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_a_idx,
  output btb_entry_t            rd_a_entry,
  input  logic [INDEX_BITS-1:0] rd_b_idx,
  output btb_entry_t            rd_b_entry,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_entry,
  input  logic                  inv_all
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]  valid_q, valid_d;
  logic [1:0]       ctr_q    [SETS];
  logic [1:0]       ctr_d    [SETS];
  logic [TAG_W-1:0] tag_q    [SETS];
  logic [TAG_W-1:0] tag_d    [SETS];
  logic [29:0]      target_q [SETS];
  logic [29:0]      target_d [SETS];

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx]  = wr_entry.valid;
      ctr_d[wr_idx]    = wr_entry.ctr;
      tag_d[wr_idx]    = wr_entry.tag;
      target_d[wr_idx] = wr_entry.target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        ctr_q[i] <= CTR_WEAK_NT;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  always_comb begin
    rd_a_entry.valid  = valid_q[rd_a_idx];
    rd_a_entry.tag    = tag_q[rd_a_idx];
    rd_a_entry.target = target_q[rd_a_idx];
    rd_a_entry.ctr    = ctr_q[rd_a_idx];
    rd_b_entry.valid  = valid_q[rd_b_idx];
    rd_b_entry.tag    = tag_q[rd_b_idx];
    rd_b_entry.target = target_q[rd_b_idx];
    rd_b_entry.ctr    = ctr_q[rd_b_idx];
  end

endmodule

// File: rtl/btb_assoc.sv
// Tagged 1/2-way branch target buffer with LRU replacement and single-cycle flush.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module btb_assoc
  import btb_types::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_allocs
);

  localparam int SETS = 1 << INDEX_BITS;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("btb_assoc: WAYS must be 1 or 2");
  end

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  btb_entry_t            lk_entry [WAYS];
  btb_entry_t            up_entry [WAYS];
  logic [WAYS-1:0]       lk_match, up_match, wr_en;
  btb_entry_t            wr_entry;

  logic        lk_sel_ctr_msb;
  logic [29:0] lk_sel_target;
  logic [1:0]  up_sel_ctr;
  logic [29:0] up_sel_target;
  logic        accepted, up_hit, hit_way, alloc, victim, way_used, write_any, lru_bit;
  logic        unused_target_lsbs;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign lk_tag = pc_tag(lookup_pc, INDEX_BITS);
  assign up_tag = pc_tag(update_pc, INDEX_BITS);
  assign unused_target_lsbs = ^update_target[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way #(.INDEX_BITS(INDEX_BITS)) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_a_idx   (lk_idx),
      .rd_a_entry (lk_entry[w]),
      .rd_b_idx   (up_idx),
      .rd_b_entry (up_entry[w]),
      .wr_en      (wr_en[w]),
      .wr_idx     (up_idx),
      .wr_entry   (wr_entry),
      .inv_all    (flush)
    );
    assign lk_match[w] = lk_entry[w].valid && (lk_entry[w].tag == lk_tag);
    assign up_match[w] = up_entry[w].valid && (up_entry[w].tag == up_tag);
  end

  // Way 0 wins a double match; target/taken are gated by hit so unwritten X never escapes.
  always_comb begin
    lk_sel_ctr_msb = lk_entry[0].ctr[1];
    lk_sel_target  = lk_entry[0].target;
    if (!lk_match[0]) begin
      lk_sel_ctr_msb = lk_entry[WAYS-1].ctr[1];
      lk_sel_target  = lk_entry[WAYS-1].target;
    end
    lookup_hit    = |lk_match;
    lookup_taken  = lookup_hit ? lk_sel_ctr_msb : 1'b0;
    lookup_target = lookup_hit ? {lk_sel_target, 2'b00} : 32'd0;
  end

  always_comb begin
    accepted  = update_valid && !flush;
    up_hit    = |up_match;
    hit_way   = (WAYS == 2) && !up_match[0];
    alloc     = accepted && !up_hit && update_taken;
    write_any = (accepted && up_hit) || alloc;

    if (!up_entry[0].valid) begin
      victim = 1'b0;
    end else if (WAYS == 2 && !up_entry[WAYS-1].valid) begin
      victim = 1'b1;
    end else begin
      victim = lru_bit;
    end
    way_used = up_hit ? hit_way : victim;

    up_sel_ctr    = hit_way ? up_entry[WAYS-1].ctr    : up_entry[0].ctr;
    up_sel_target = hit_way ? up_entry[WAYS-1].target : up_entry[0].target;

    wr_entry.valid = 1'b1;
    wr_entry.tag   = up_tag;
    if (up_hit) begin
      wr_entry.target = update_taken ? update_target[31:2] : up_sel_target;
      wr_entry.ctr    = sat_update(up_sel_ctr, update_taken);
    end else begin
      wr_entry.target = update_target[31:2];
      wr_entry.ctr    = CTR_WEAK_T;
    end

    for (int w = 0; w < WAYS; w++) begin
      wr_en[w] = write_any && (way_used == 1'(w));
    end
  end

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q, lru_d;

    // LRU points at the way that was not touched by the latest hit or allocation.
    always_comb begin
      lru_d = lru_q;
      if (write_any) begin
        lru_d[up_idx] = ~way_used;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lru_q <= '0;
      end else begin
        lru_q <= lru_d;
      end
    end

    assign lru_bit = lru_q[up_idx];
  end else begin : g_no_lru
    assign lru_bit = 1'b0;
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_allocs_q, stat_allocs_d;

  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_allocs_d  = stat_allocs_q;
    if (accepted && stat_updates_q != 32'hFFFF_FFFF) begin
      stat_updates_d = stat_updates_q + 32'd1;
    end
    if (alloc && stat_allocs_q != 32'hFFFF_FFFF) begin
      stat_allocs_d = stat_allocs_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates_q <= '0;
      stat_allocs_q  <= '0;
    end else begin
      stat_updates_q <= stat_updates_d;
      stat_allocs_q  <= stat_allocs_d;
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_allocs  = stat_allocs_q;
`else
  assign stat_updates = 32'd0;
  assign stat_allocs  = 32'd0;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus randomized traffic
// compared against a behavioural set/way model.
module tb_btb_assoc;

  localparam int IB   = 6;
  localparam int WAYS = 2;
  localparam int SETS = 1 << IB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_hit, lookup_taken;
  logic [31:0] lookup_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;
  logic [31:0] stat_updates, stat_allocs;

  always #5 clk = ~clk;

  btb_assoc #(.INDEX_BITS(IB), .WAYS(WAYS)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (lookup_pc),
    .lookup_hit    (lookup_hit),
    .lookup_taken  (lookup_taken),
    .lookup_target (lookup_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .flush         (flush),
    .stat_updates  (stat_updates),
    .stat_allocs   (stat_allocs)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one record per (way, set), plus per-set LRU and counters.
  bit          m_valid [WAYS][SETS];
  int unsigned m_tag   [WAYS][SETS];
  logic [31:0] m_tgt   [WAYS][SETS];
  int          m_ctr   [WAYS][SETS];
  int          m_lru   [SETS];
  int          m_upd;
  int          m_alloc;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] pc, output bit hit, output bit taken,
                                       output logic [31:0] tgt);
    int s = int'(pc[IB+1:2]);
    int unsigned t = pc >> (IB + 2);
    hit = 0; taken = 0; tgt = 32'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m_valid[w][s] && m_tag[w][s] == t) begin
        hit   = 1;
        taken = (m_ctr[w][s] >= 2);
        tgt   = {m_tgt[w][s][31:2], 2'b00};
      end
    end
  endfunction

  function automatic void model_update(input bit v, input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tg, input bit fl, input bit r);
    int s = int'(pc[IB+1:2]);
    int unsigned t = pc >> (IB + 2);
    int hw = -1;
    int vic;
    if (r) begin
      for (int w = 0; w < WAYS; w++)
        for (int i = 0; i < SETS; i++) begin
          m_valid[w][i] = 0;
          m_ctr[w][i]   = 1;
        end
      for (int i = 0; i < SETS; i++) m_lru[i] = 0;
      m_upd = 0; m_alloc = 0;
      return;
    end
    if (fl) begin
      for (int w = 0; w < WAYS; w++)
        for (int i = 0; i < SETS; i++) m_valid[w][i] = 0;
      return;
    end
    if (!v) return;
    m_upd++;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_valid[w][s] && m_tag[w][s] == t) hw = w;
    if (hw >= 0) begin
      if (tk) begin
        m_ctr[hw][s] = (m_ctr[hw][s] == 3) ? 3 : m_ctr[hw][s] + 1;
        m_tgt[hw][s] = tg;
      end else begin
        m_ctr[hw][s] = (m_ctr[hw][s] == 0) ? 0 : m_ctr[hw][s] - 1;
      end
      m_lru[s] = 1 - hw;
    end else if (tk) begin
      if (!m_valid[0][s]) vic = 0;
      else if (!m_valid[1][s]) vic = 1;
      else vic = m_lru[s];
      m_valid[vic][s] = 1;
      m_tag[vic][s]   = t;
      m_tgt[vic][s]   = tg;
      m_ctr[vic][s]   = 2;
      m_lru[s]        = 1 - vic;
      m_alloc++;
    end
  endfunction

  task automatic checkStats(input string tag, input int exp_upd, input int exp_alloc);
`ifdef BTB_STATS_EN
    checkOutput({tag, "_updates"}, stat_updates, 32'(exp_upd));
    checkOutput({tag, "_allocs"}, stat_allocs, 32'(exp_alloc));
`else
    checkOutput({tag, "_updates"}, stat_updates, 32'd0);
    checkOutput({tag, "_allocs"}, stat_allocs, 32'd0);
`endif
  endtask

  // One cycle of traffic: outputs are compared with the model before the edge commits.
  task automatic applyStimulus(input bit v, input logic [31:0] upc, input bit tk,
                               input logic [31:0] tg, input bit fl, input bit r,
                               input logic [31:0] lpc);
    bit eh, et;
    logic [31:0] etg;
    @(negedge clk);
    update_valid = v; update_pc = upc; update_taken = tk; update_target = tg;
    flush = fl; rst = r; lookup_pc = lpc;
    #1;
    model_lookup(lpc, eh, et, etg);
    checkOutput("hit", 32'(lookup_hit), 32'(eh));
    checkOutput("taken", 32'(lookup_taken), 32'(et));
    checkOutput("target", lookup_target, etg);
    checkStats("stats", m_upd, m_alloc);
    @(posedge clk);
    model_update(v, upc, tk, tg, fl, r);
  endtask

  task automatic lookupExpect(input string tag, input logic [31:0] pc, input bit eh,
                              input bit et, input logic [31:0] etg);
    @(negedge clk);
    update_valid = 0; flush = 0; rst = 0; lookup_pc = pc;
    #1;
    checkOutput({tag, "_hit"}, 32'(lookup_hit), 32'(eh));
    checkOutput({tag, "_taken"}, 32'(lookup_taken), 32'(et));
    checkOutput({tag, "_target"}, lookup_target, etg);
    @(posedge clk);
  endtask

  task automatic update1(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    applyStimulus(1, pc, tk, tg, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; flush = 0; update_valid = 0; update_pc = 0; update_taken = 0;
    update_target = 0; lookup_pc = 0;
    @(posedge clk);
    @(posedge clk);
    model_update(0, 0, 0, 0, 0, 1);

    lookupExpect("reset", 32'h100, 0, 0, 32'h0);

    update1(32'h100, 1, 32'h200);
    lookupExpect("alloc", 32'h100, 1, 1, 32'h200);
    lookupExpect("neighbour", 32'h104, 0, 0, 32'h0);

    update1(32'h100, 0, 32'h999);
    update1(32'h100, 0, 32'h999);
    lookupExpect("ctr_min", 32'h100, 1, 0, 32'h200);
    update1(32'h100, 1, 32'h200);
    update1(32'h100, 1, 32'h200);
    update1(32'h100, 1, 32'h200);
    lookupExpect("ctr_max", 32'h100, 1, 1, 32'h200);

    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    update1(32'h100, 1, 32'h200);
    update1(32'h1100, 1, 32'h1200);
    update1(32'h100, 1, 32'h200);
    update1(32'h2100, 1, 32'h2200);
    lookupExpect("evicted", 32'h1100, 0, 0, 32'h0);
    lookupExpect("kept", 32'h100, 1, 1, 32'h200);
    lookupExpect("newway", 32'h2100, 1, 1, 32'h2200);

    @(negedge clk);
    update_valid = 1; update_pc = 32'h300; update_taken = 1; update_target = 32'h500;
    flush = 0; rst = 0; lookup_pc = 32'h300;
    #1;
    checkOutput("same_cycle_hit", 32'(lookup_hit), 32'd0);
    @(posedge clk);
    model_update(1, 32'h300, 1, 32'h500, 0, 0);
    lookupExpect("after_write", 32'h300, 1, 1, 32'h500);

    applyStimulus(1, 32'h400, 1, 32'h800, 1, 0, 32'h300);
    lookupExpect("flush_upd", 32'h400, 0, 0, 32'h0);
    lookupExpect("flush_old", 32'h300, 0, 0, 32'h0);
    lookupExpect("flush_old2", 32'h2100, 0, 0, 32'h0);

    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    update1(32'h104, 1, 32'h40);
    update1(32'h108, 1, 32'h80);
    update1(32'h10C, 1, 32'hC0);
    update1(32'h110, 0, 32'h0);
    update1(32'h114, 0, 32'h0);
    @(negedge clk);
    update_valid = 0;
    #1;
    checkStats("stats5", 5, 3);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    @(negedge clk);
    #1;
    checkStats("stats_flush", 5, 3);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0);
    @(negedge clk);
    #1;
    checkStats("stats_rst", 0, 0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] upc, lpc, tg;
      upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      lpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      tg  = $urandom;
      applyStimulus($urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0, tg,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0, lpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised, tagged, set-associative branch target buffer for the RV32I fetch stage.
- Fetch presents its PC and gets a same-cycle hit, direction and target prediction.
- EX/branch resolution writes results back through a registered update port.
- Adds over the previous generation: per-entry valid bits and tags, a 2-bit saturating direction counter per entry, 1 or 2 ways with LRU replacement, and a single-cycle flush.

Parameters:
- INDEX_BITS, 6, log2 of number of sets (64 sets by default).
- WAYS, 2, associativity; legal values 1 or 2; any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  32  fetch PC.
- lookup_hit  output  1  a valid entry tag-matches lookup_pc.
- lookup_taken  output  1  lookup_hit and the entry's counter MSB is 1.
- lookup_target  output  32  predicted target; 0 when no hit.
- update_valid  input  1  qualifies the update_* fields for one cycle.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  resolved direction.
- update_target  input  32  resolved target address.
- flush  input  1  invalidate all entries.
- stat_updates  output  32  count of accepted updates (BTB_STATS_EN).
- stat_allocs  output  32  count of allocations (BTB_STATS_EN).

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
  - stored target = target[31:2]; lookup_target low 2 bits are always 00.
- Lookup is purely combinational from the flop array, with zero latency.
  - Hit when a way's valid bit is set and its tag equals the lookup tag.
  - If both ways match (illegal state), way 0 wins.
- Update is registered; its effect is visible to lookup from the cycle after update_valid.
  - A same-cycle lookup of the same entry sees the old contents.
- Update, hit in way w:
  - Counter saturates: +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
  - Target is overwritten only when update_taken=1.
  - LRU[set] becomes the other way (WAYS=2).
- Update, miss, taken (allocation):
  - Victim selection: first invalid way, way 0 first; otherwise the way named by LRU[set].
  - Victim is written with valid=1, the new tag and target, and counter=2'b10 (weakly taken).
  - LRU[set] becomes the other way.
- Update, miss, not taken: no state change.
- Reset (rst=1 at a clock edge): all valid bits=0, all counters=2'b01, all LRU=0, stat counters=0.
  - Therefore lookup_hit=0, lookup_taken=0 and lookup_target=0 in the first cycle after reset.
  - rst overrides flush and update in the same cycle.
- Flush: on the next edge all valid bits=0; tags, targets, counters and LRU are untouched.
  - flush overrides a same-cycle update; that update is dropped and not counted.
- WAYS=1: direct-mapped; the LRU array is not generated and allocation always replaces way 0.
- Tags and targets are not reset, so their contents are X before the first write.
  - Output logic must gate target and taken with hit so that X never reaches the outputs.

Optional Feature:
Macro BTB_STATS_EN.
- Defined:
  - stat_updates increments on every accepted update (update_valid=1, flush=0, rst=0).
  - stat_allocs increments on every allocation.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF; both are cleared by rst but not by flush.
- Undefined: the ports remain present and are tied to 32'b0; no counter flops are generated.

Decomposition:
- Package btb_types:
  - btb_entry_t struct {valid, tag, target[29:0], ctr[1:0]}.
  - Constants CTR_WEAK_NT=2'b01, CTR_WEAK_T=2'b10, CTR_MAX=2'b11.
  - Function sat_update(ctr, taken).
- Sub-module btb_way: one way's entry array, with a combinational read port and a registered write port with per-index write enable and global invalidate. It is instantiated WAYS times.
- LRU array, victim select and stats live in btb_assoc.

Test Plan (defaults, INDEX_BITS=6, WAYS=2):
- Reset, then lookup 0x0000_0100 -> lookup_hit=0, lookup_taken=0, lookup_target=0.
- Update pc=0x100, taken, target=0x200; next cycle lookup 0x100 -> hit=1, taken=1, target=0x0000_0200. Lookup 0x104 -> hit=0.
- Counter walk: two not-taken updates to 0x100 -> counter 10->01->00, hit=1, taken=0. Three taken updates -> counter saturates at 11, taken=1.
- Replacement (sets all index 0):
  - allocate 0x100 (way0) then 0x1100 (way1);
  - hit-update 0x100 (LRU now points to way1);
  - allocate 0x2100 -> 0x1100 evicted (miss); 0x100 and 0x2100 hit.
- Same-cycle: update 0x300 taken while lookup 0x300 -> hit=0 that cycle, hit=1 next. flush with update 0x400 -> 0x400 misses and every prior entry misses.
- BTB_STATS_EN: 5 updates, of which 3 are taken misses on distinct sets and 2 are not-taken misses -> stat_updates=5, stat_allocs=3. Flush leaves both values unchanged; rst clears both to 0.
